ace_mem_sub: RTL and testbench

//  ACE subordinate (responder) end of the port driven by the LSU and other core masters.

---
 rtl/ace_mem_sub_pkg.sv | 33 +++
 rtl/ace_if.sv | 50 +++++
 rtl/sram_1rw.sv | 32 +++
 rtl/ace_mem_sub.sv | 166 ++++++++++++++++
 tb/tb_ace_mem_sub.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ace_mem_sub_pkg.sv
// Shared widths, response codes, FSM states and the captured-request payload
// for the ACE block-RAM subordinate.
package ace_mem_sub_pkg;

    localparam int unsigned ADDR_WIDTH         = 32;
    localparam int unsigned BLOCK_SIZE         = 128;
    localparam int unsigned ID_WIDTH           = 4;
    localparam int unsigned LEN_WIDTH          = 8;
    localparam int unsigned STRB_WIDTH         = BLOCK_SIZE / 8;
    localparam int unsigned BLOCK_OFFSET_WIDTH = $clog2(STRB_WIDTH);

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } ace_resp_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_MEM  = 3'd1,
        RD_RESP = 3'd2,
        WR_DATA = 3'd3,
        WR_RESP = 3'd4
    } ace_mem_sub_state_e;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
    } ace_req_t;

endpackage

// File: rtl/ace_if.sv
// ACE port between core masters and a memory subordinate; snoop channels carry
// only the handshake wires the subordinate ties off.
interface ace_if;
    import ace_mem_sub_pkg::*;

    logic                  awvalid;
    logic                  awready;
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [LEN_WIDTH-1:0]  awlen;

    logic                  wvalid;
    logic                  wready;
    logic [BLOCK_SIZE-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;

    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [LEN_WIDTH-1:0]  arlen;

    logic                  rvalid;
    logic                  rready;
    logic [ID_WIDTH-1:0]   rid;
    logic [BLOCK_SIZE-1:0] rdata;
    logic [3:0]            rresp;
    logic                  rlast;

    logic                  acvalid;
    logic                  crready;
    logic                  cdready;

    modport s (
        input  awvalid, awid, awaddr, awlen,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        input  arvalid, arid, araddr, arlen,
        input  rready,
        output awready, wready, bvalid, bid, bresp,
        output arready, rvalid, rid, rdata, rresp, rlast,
        output acvalid, crready, cdready
    );
endinterface

// File: rtl/sram_1rw.sv
// Single-port RAM with byte enables; read data registered one cycle after en.
module sram_1rw #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [WIDTH/8-1:0]       be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Array is deliberately not reset so contents survive a port reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned b = 0; b < WIDTH / 8; b++) begin
                    if (be[b]) begin
                        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/ace_mem_sub.sv
// ACE subordinate serving one INCR read or write burst at a time from block RAM;
// snoop channels are tied off.
module ace_mem_sub
    import ace_mem_sub_pkg::*;
#(
    parameter int unsigned           DEPTH     = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic clk,
    input  logic rst,
    ace_if.s     ace_sif
);

    localparam int unsigned IDX_WIDTH  = $clog2(DEPTH);
    localparam int unsigned BEAT_BYTES = BLOCK_SIZE / 8;

    ace_mem_sub_state_e    state, state_nxt;
    ace_req_t              req_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic                  run_q;
    logic                  rd_decerr_q;
    logic                  wr_decerr_q;
    logic                  wr_slverr_q;

    logic [ADDR_WIDTH-1:0] offset_c;
    logic [ADDR_WIDTH-1:0] word_c;
    logic                  in_range_c;
    logic [IDX_WIDTH-1:0]  idx_c;
    logic                  last_beat_c;
    logic                  aw_hs_c, ar_hs_c, w_hs_c, r_hs_c;
    logic                  ram_en_c, ram_we_c;
    logic [BLOCK_SIZE-1:0] ram_rdata;

    // Current beat decode against the RAM window.
    assign offset_c    = req_q.addr - BASE_ADDR;
    assign word_c      = offset_c >> BLOCK_OFFSET_WIDTH;
    assign in_range_c  = (req_q.addr >= BASE_ADDR) && (word_c < ADDR_WIDTH'(DEPTH));
    assign idx_c       = word_c[IDX_WIDTH-1:0];
    assign last_beat_c = (cnt_q == req_q.len);

    // Write wins when AW and AR arrive together; run_q keeps IDLE silent during reset.
    assign aw_hs_c = (state == IDLE) && run_q && ace_sif.awvalid;
    assign ar_hs_c = (state == IDLE) && run_q && !ace_sif.awvalid && ace_sif.arvalid;
    assign w_hs_c  = (state == WR_DATA) && ace_sif.wvalid;
    assign r_hs_c  = (state == RD_RESP) && ace_sif.rready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (aw_hs_c) begin
                    state_nxt = WR_DATA;
                end else if (ar_hs_c) begin
                    state_nxt = RD_MEM;
                end
            end
            RD_MEM:  state_nxt = RD_RESP;
            RD_RESP: if (ace_sif.rready) state_nxt = last_beat_c ? IDLE : RD_MEM;
            WR_DATA: if (ace_sif.wvalid && last_beat_c) state_nxt = WR_RESP;
            WR_RESP: if (ace_sif.bready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ace_sif.awready = 1'b0;
        ace_sif.arready = 1'b0;
        ace_sif.wready  = 1'b0;
        ace_sif.bvalid  = 1'b0;
        ace_sif.bid     = '0;
        ace_sif.bresp   = '0;
        ace_sif.rvalid  = 1'b0;
        ace_sif.rid     = '0;
        ace_sif.rdata   = '0;
        ace_sif.rresp   = '0;
        ace_sif.rlast   = 1'b0;
        ace_sif.acvalid = 1'b0;
        ace_sif.crready = run_q;
        ace_sif.cdready = run_q;
        ram_en_c        = 1'b0;
        ram_we_c        = 1'b0;
        unique case (state)
            IDLE: begin
                ace_sif.awready = run_q;
                ace_sif.arready = run_q && !ace_sif.awvalid;
            end
            RD_MEM: begin
                ram_en_c = in_range_c && !rst;
            end
            RD_RESP: begin
                ace_sif.rvalid = 1'b1;
                ace_sif.rid    = req_q.id;
                ace_sif.rdata  = rd_decerr_q ? '0 : ram_rdata;
                ace_sif.rresp  = {2'b00, rd_decerr_q ? DECERR : OKAY};
                ace_sif.rlast  = last_beat_c;
            end
            WR_DATA: begin
                ace_sif.wready = 1'b1;
                ram_en_c       = ace_sif.wvalid && in_range_c && !rst;
                ram_we_c       = 1'b1;
            end
            WR_RESP: begin
                ace_sif.bvalid = 1'b1;
                ace_sif.bid    = req_q.id;
                ace_sif.bresp  = wr_decerr_q ? DECERR : (wr_slverr_q ? SLVERR : OKAY);
            end
            default: ;
        endcase
    end

    // Request capture, beat counter, address stepping and error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q       <= 1'b0;
            req_q       <= '0;
            cnt_q       <= '0;
            rd_decerr_q <= 1'b0;
            wr_decerr_q <= 1'b0;
            wr_slverr_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (aw_hs_c) begin
                req_q       <= '{id: ace_sif.awid, addr: ace_sif.awaddr, len: ace_sif.awlen};
                cnt_q       <= '0;
                wr_decerr_q <= 1'b0;
                wr_slverr_q <= 1'b0;
            end else if (ar_hs_c) begin
                req_q <= '{id: ace_sif.arid, addr: ace_sif.araddr, len: ace_sif.arlen};
                cnt_q <= '0;
            end
            if (state == RD_MEM) begin
                rd_decerr_q <= !in_range_c;
            end
            if ((r_hs_c && !last_beat_c) || w_hs_c) begin
                cnt_q      <= cnt_q + LEN_WIDTH'(1);
                req_q.addr <= req_q.addr + ADDR_WIDTH'(BEAT_BYTES);
            end
            if (w_hs_c) begin
                if (!in_range_c) wr_decerr_q <= 1'b1;
                if (ace_sif.wlast != last_beat_c) wr_slverr_q <= 1'b1;
            end
        end
    end

    sram_1rw #(
        .WIDTH (BLOCK_SIZE),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en_c),
        .we    (ram_we_c),
        .be    (ace_sif.wstrb),
        .addr  (idx_c),
        .wdata (ace_sif.wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_ace_mem_sub.sv
// Directed bench for ace_mem_sub: single stores, bursts, backpressure,
// AW/AR arbitration, decode errors and reset recovery.
module tb_ace_mem_sub;

    localparam int TMO = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   errors = 0;
    int   cyc = 0;

    ace_if sif ();

    ace_mem_sub #(
        .DEPTH     (1024),
        .BASE_ADDR (32'h8000_0000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ace_sif (sif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, need finish", $time);
        $fatal(1);
    end

    function automatic logic [127:0] pat(input int i);
        return {32'hCAFE_0000 + 32'(i), 32'hBEEF_0000 + 32'(i),
                32'hF00D_0000 + 32'(i), 32'hD00D_0000 + 32'(i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        int n = 0;
        sif.awaddr = a; sif.awid = id; sif.awlen = len; sif.awvalid = 1'b1;
        #1;
        while (sif.awready !== 1'b1 && n < TMO) begin tick(); n++; end
        if (n == TMO) begin
            tests++; errors++;
            $display("FAIL aw_timeout: awready low for %0d cycles, need 1", n);
        end
        tick();
        sif.awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [127:0] d, input logic [15:0] strb, input logic last);
        int n = 0;
        sif.wdata = d; sif.wstrb = strb; sif.wlast = last; sif.wvalid = 1'b1;
        #1;
        while (sif.wready !== 1'b1 && n < TMO) begin tick(); n++; end
        if (n == TMO) begin
            tests++; errors++;
            $display("FAIL w_timeout: wready low for %0d cycles, need 1", n);
        end
        tick();
        sif.wvalid = 1'b0;
    endtask

    task automatic b_recv(output logic [1:0] resp, output logic [3:0] id);
        int n = 0;
        sif.bready = 1'b1;
        #1;
        while (sif.bvalid !== 1'b1 && n < TMO) begin tick(); n++; end
        if (n == TMO) begin
            tests++; errors++;
            $display("FAIL b_timeout: bvalid low for %0d cycles, need 1", n);
        end
        resp = sif.bresp; id = sif.bid;
        tick();
        sif.bready = 1'b0;
    endtask

    task automatic ar_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           output int hs_cyc);
        int n = 0;
        sif.araddr = a; sif.arid = id; sif.arlen = len; sif.arvalid = 1'b1;
        #1;
        while (sif.arready !== 1'b1 && n < TMO) begin tick(); n++; end
        if (n == TMO) begin
            tests++; errors++;
            $display("FAIL ar_timeout: arready low for %0d cycles, need 1", n);
        end
        hs_cyc = cyc;
        tick();
        sif.arvalid = 1'b0;
    endtask

    task automatic r_recv(output logic [127:0] d, output logic [3:0] resp, output logic last,
                          output logic [3:0] id, output int rv_cyc);
        int n = 0;
        sif.rready = 1'b1;
        #1;
        while (sif.rvalid !== 1'b1 && n < TMO) begin tick(); n++; end
        if (n == TMO) begin
            tests++; errors++;
            $display("FAIL r_timeout: rvalid low for %0d cycles, need 1", n);
        end
        d = sif.rdata; resp = sif.rresp; last = sif.rlast; id = sif.rid; rv_cyc = cyc;
        tick();
        sif.rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0]   flags;
        logic [141:0] bus;
        rst = 1'b1;
        repeat (3) tick();
        flags = {sif.awready, sif.arready, sif.wready, sif.bvalid, sif.rvalid,
                 sif.rlast, sif.acvalid, sif.crready, sif.cdready};
        bus = {sif.rdata, sif.rresp, sif.bresp, sif.rid, sif.bid};
        tests++;
        if (flags !== 9'b0) begin
            errors++; $display("FAIL reset_flags: got %b need %b", flags, 9'b0);
        end
        tests++;
        if (bus !== 142'b0) begin
            errors++; $display("FAIL reset_data: got %h need 0", bus);
        end
        rst = 1'b0;
        tick();
        flags = {sif.awready, sif.arready, sif.wready, sif.bvalid, sif.rvalid,
                 sif.rlast, sif.acvalid, sif.crready, sif.cdready};
        tests++;
        if (flags !== 9'b110000011) begin
            errors++; $display("FAIL idle_flags: got %b need %b", flags, 9'b110000011);
        end
    endtask

    task automatic test_single_write();
        logic [1:0]   br;
        logic [3:0]   bi, rr, ri;
        logic [127:0] d;
        logic         last;
        int           hs, rv;
        aw_send(32'h8000_0000, 4'h1, 8'd0);
        w_send(128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 16'hFFFF, 1'b1);
        b_recv(br, bi);
        tests++;
        if ({br, bi} !== {2'b00, 4'h1}) begin
            errors++; $display("FAIL sw_fill_b: got resp %b id %h need 00 1", br, bi);
        end
        aw_send(32'h8000_0004, 4'h2, 8'd0);
        w_send(128'h1111_1111_2222_2222_DEAD_BEEF_3333_3333, 16'h00F0, 1'b1);
        b_recv(br, bi);
        tests++;
        if ({br, bi} !== {2'b00, 4'h2}) begin
            errors++; $display("FAIL sw_lane_b: got resp %b id %h need 00 2", br, bi);
        end
        ar_send(32'h8000_0000, 4'h3, 8'd0, hs);
        r_recv(d, rr, last, ri, rv);
        tests++;
        if (d !== 128'h0011_2233_4455_6677_DEAD_BEEF_CCDD_EEFF) begin
            errors++; $display("FAIL sw_readback: got %h need %h", d,
                               128'h0011_2233_4455_6677_DEAD_BEEF_CCDD_EEFF);
        end
        tests++;
        if ({rr, last, ri} !== {4'b0000, 1'b1, 4'h3}) begin
            errors++; $display("FAIL sw_read_ctl: got resp %b last %b id %h need 0000 1 3", rr, last, ri);
        end
    endtask

    task automatic test_burst_read();
        logic [1:0]   br;
        logic [3:0]   bi, rr, ri;
        logic [127:0] d;
        logic         last;
        int           hs, rv, prev;
        aw_send(32'h8000_0010, 4'h4, 8'd3);
        for (int i = 0; i < 4; i++) w_send(pat(i + 1), 16'hFFFF, 1'(i == 3));
        b_recv(br, bi);
        tests++;
        if ({br, bi} !== {2'b00, 4'h4}) begin
            errors++; $display("FAIL burst_write_b: got resp %b id %h need 00 4", br, bi);
        end
        ar_send(32'h8000_0010, 4'h5, 8'd3, hs);
        prev = hs;
        for (int i = 0; i < 4; i++) begin
            r_recv(d, rr, last, ri, rv);
            tests++;
            if (d !== pat(i + 1)) begin
                errors++; $display("FAIL burst_data%0d: got %h need %h", i, d, pat(i + 1));
            end
            tests++;
            if ({rr, last, ri} !== {4'b0000, 1'(i == 3), 4'h5}) begin
                errors++; $display("FAIL burst_ctl%0d: got resp %b last %b id %h need 0000 %0d 5",
                                   i, rr, last, ri, i == 3);
            end
            tests++;
            if ((rv - prev) !== 2) begin
                errors++; $display("FAIL burst_lat%0d: got %0d cycles need 2", i, rv - prev);
            end
            prev = rv;
        end
    endtask

    task automatic test_read_backpressure();
        logic [3:0]   rr, ri;
        logic [127:0] d;
        logic [136:0] snap;
        logic         last, stable;
        int           hs, rv, n;
        ar_send(32'h8000_0010, 4'h6, 8'd3, hs);
        r_recv(d, rr, last, ri, rv);
        tests++;
        if (d !== pat(1)) begin
            errors++; $display("FAIL bp_beat0: got %h need %h", d, pat(1));
        end
        sif.rready = 1'b0;
        n = 0;
        #1;
        while (sif.rvalid !== 1'b1 && n < TMO) begin tick(); n++; end
        snap = {sif.rdata, sif.rresp, sif.rlast, sif.rid};
        stable = 1'b1;
        repeat (5) begin
            tick();
            if ({sif.rvalid, sif.rdata, sif.rresp, sif.rlast, sif.rid} !== {1'b1, snap}) stable = 1'b0;
        end
        tests++;
        if (stable !== 1'b1) begin
            errors++; $display("FAIL bp_stable: got %b need 1", stable);
        end
        tests++;
        if (snap !== {pat(2), 4'b0000, 1'b0, 4'h6}) begin
            errors++; $display("FAIL bp_held_beat: got %h need %h", snap, {pat(2), 4'b0000, 1'b0, 4'h6});
        end
        for (int i = 1; i < 4; i++) begin
            r_recv(d, rr, last, ri, rv);
            tests++;
            if ({d, last} !== {pat(i + 1), 1'(i == 3)}) begin
                errors++; $display("FAIL bp_beat%0d: got %h last %b need %h last %0d",
                                   i, d, last, pat(i + 1), i == 3);
            end
        end
    endtask

    task automatic test_aw_ar_collision();
        logic [1:0]   br;
        logic [3:0]   bi, rr, ri;
        logic [127:0] d;
        logic         last;
        int           rv;
        sif.awaddr = 32'h8000_0050; sif.awid = 4'h7; sif.awlen = 8'd0; sif.awvalid = 1'b1;
        sif.araddr = 32'h8000_0050; sif.arid = 4'h8; sif.arlen = 8'd0; sif.arvalid = 1'b1;
        #1;
        tests++;
        if ({sif.awready, sif.arready} !== 2'b10) begin
            errors++; $display("FAIL collide_ready: got aw/ar %b need 10", {sif.awready, sif.arready});
        end
        tick();
        sif.awvalid = 1'b0;
        #1;
        tests++;
        if (sif.arready !== 1'b0) begin
            errors++; $display("FAIL collide_ar_wdata: got arready %b need 0", sif.arready);
        end
        w_send({4{32'h5A5A_0F0F}}, 16'hFFFF, 1'b1);
        tests++;
        if ({sif.bvalid, sif.arready} !== 2'b10) begin
            errors++; $display("FAIL collide_ar_wresp: got bvalid/arready %b need 10",
                               {sif.bvalid, sif.arready});
        end
        b_recv(br, bi);
        tests++;
        if ({br, bi} !== {2'b00, 4'h7}) begin
            errors++; $display("FAIL collide_b: got resp %b id %h need 00 7", br, bi);
        end
        #1;
        tests++;
        if (sif.arready !== 1'b1) begin
            errors++; $display("FAIL collide_ar_after_b: got arready %b need 1", sif.arready);
        end
        tick();
        sif.arvalid = 1'b0;
        r_recv(d, rr, last, ri, rv);
        tests++;
        if ({d, ri} !== {{4{32'h5A5A_0F0F}}, 4'h8}) begin
            errors++; $display("FAIL collide_read: got %h id %h need %h id 8", d, ri, {4{32'h5A5A_0F0F}});
        end
    endtask

    task automatic test_decerr();
        logic [1:0]   br;
        logic [3:0]   bi, rr, ri;
        logic [127:0] d;
        logic         last;
        int           hs, rv;
        ar_send(32'h7FFF_FFF0, 4'h9, 8'd0, hs);
        r_recv(d, rr, last, ri, rv);
        tests++;
        if ({d, rr, last, ri} !== {128'b0, 4'b0011, 1'b1, 4'h9}) begin
            errors++; $display("FAIL decerr_read: got data %h resp %b last %b id %h need 0 0011 1 9",
                               d, rr, last, ri);
        end
        aw_send(32'h8000_4000, 4'hA, 8'd0);
        w_send({4{32'hBAD0_BAD0}}, 16'hFFFF, 1'b1);
        b_recv(br, bi);
        tests++;
        if ({br, bi} !== {2'b11, 4'hA}) begin
            errors++; $display("FAIL decerr_write: got resp %b id %h need 11 a", br, bi);
        end
        aw_send(32'h8000_3FF0, 4'hB, 8'd0);
        w_send(pat(1023), 16'hFFFF, 1'b1);
        b_recv(br, bi);
        tests++;
        if (br !== 2'b00) begin
            errors++; $display("FAIL top_word_write: got resp %b need 00", br);
        end
        ar_send(32'h8000_0000, 4'hC, 8'd0, hs);
        r_recv(d, rr, last, ri, rv);
        tests++;
        if (d !== 128'h0011_2233_4455_6677_DEAD_BEEF_CCDD_EEFF) begin
            errors++; $display("FAIL decerr_ram_intact: got %h need %h", d,
                               128'h0011_2233_4455_6677_DEAD_BEEF_CCDD_EEFF);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [1:0]   br;
        logic [3:0]   bi, rr, ri;
        logic [127:0] d;
        logic [141:0] bus;
        logic [8:0]   flags;
        logic         last;
        int           hs, rv;
        aw_send(32'h8000_0100, 4'hB, 8'd3);
        w_send(pat(16), 16'hFFFF, 1'b0);
        w_send(pat(17), 16'hFFFF, 1'b0);
        sif.wdata = pat(18); sif.wstrb = 16'hFFFF; sif.wlast = 1'b0; sif.wvalid = 1'b1;
        rst = 1'b1;
        tick();
        flags = {sif.awready, sif.arready, sif.wready, sif.bvalid, sif.rvalid,
                 sif.rlast, sif.acvalid, sif.crready, sif.cdready};
        bus = {sif.rdata, sif.rresp, sif.bresp, sif.rid, sif.bid};
        tests++;
        if ({flags, bus} !== 151'b0) begin
            errors++; $display("FAIL midrst_outputs: got flags %b data %h need 0", flags, bus);
        end
        sif.wvalid = 1'b0;
        rst = 1'b0;
        tick();
        ar_send(32'h8000_0100, 4'hC, 8'd1, hs);
        for (int i = 0; i < 2; i++) begin
            r_recv(d, rr, last, ri, rv);
            tests++;
            if ({d, rr, last} !== {pat(16 + i), 4'b0000, 1'(i == 1)}) begin
                errors++; $display("FAIL midrst_kept%0d: got %h resp %b last %b need %h 0000 %0d",
                                   i, d, rr, last, pat(16 + i), i == 1);
            end
        end
        aw_send(32'h8000_0200, 4'hD, 8'd3);
        w_send(pat(32), 16'hFFFF, 1'b0);
        w_send(pat(33), 16'hFFFF, 1'b1);
        w_send(pat(34), 16'hFFFF, 1'b0);
        w_send(pat(35), 16'hFFFF, 1'b0);
        b_recv(br, bi);
        tests++;
        if ({br, bi} !== {2'b10, 4'hD}) begin
            errors++; $display("FAIL early_wlast: got resp %b id %h need 10 d", br, bi);
        end
    endtask

    initial begin
        sif.awvalid = 1'b0; sif.awaddr = '0; sif.awid = '0; sif.awlen = '0;
        sif.wvalid  = 1'b0; sif.wdata  = '0; sif.wstrb = '0; sif.wlast = 1'b0;
        sif.bready  = 1'b0;
        sif.arvalid = 1'b0; sif.araddr = '0; sif.arid = '0; sif.arlen = '0;
        sif.rready  = 1'b0;
        test_reset();
        test_single_write();
        test_burst_read();
        test_read_backpressure();
        test_aw_ar_collision();
        test_decerr();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
